// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: obstacle slot pool with LFSR-timed spawning, stepwise scrolling and per-pixel palette index.
module obstacle_scheduler #(
  parameter int NSLOT    = 4,
  parameter int CIDXW    = 3,
  parameter int MOVE_DIV = 2,
  parameter int SPEED    = 4,
  parameter int MIN_GAP  = 12,
  parameter int GROUND_Y = 400,
  parameter int LEFT_X   = 144,
  parameter int RIGHT_X  = 784
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic             frame_tick,
  input  logic [9:0]       hCount,
  input  logic [9:0]       vCount,
  output logic [CIDXW:0]   pix,
  output logic [NSLOT-1:0] active_mask,
  output logic [15:0]      spawn_count
);
  localparam int DW = MOVE_DIV > 1 ? $clog2(MOVE_DIV) : 1;
  localparam int GW = $clog2(MIN_GAP + 16);
  localparam int IW = $clog2(NSLOT);
  localparam logic [10:0] GY = 11'(GROUND_Y);
  logic [15:0]                lfsr_q;
  logic [DW-1:0]              div_q, div_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic [NSLOT-1:0]           val_q, val_d;
  logic [NSLOT-1:0][9:0]      x_q, x_d;
  logic [NSLOT-1:0][1:0]      typ_q, typ_d;
  logic [15:0]                cnt_q, cnt_d;
  logic [CIDXW:0]             pix_q, pix_d;
  logic                       tick, step, spawn;
  logic [IW-1:0]              free_idx;
  logic [10:0]                h11, v11, x11, top, bot;
  logic [1:0]                 t;
  always_comb begin
    tick = !clear && run && frame_tick;
    step = tick && div_q == DW'(MOVE_DIV - 1);
    free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--)
      if (!val_q[i]) free_idx = IW'(i);
    spawn = step && gap_q == '0 && !(&val_q);
    div_d = clear ? '0 : tick ? (step ? '0 : div_q + DW'(1)) : div_q;
    gap_d = clear ? GW'(MIN_GAP) : spawn ? GW'(MIN_GAP) + GW'(lfsr_q[5:2]) :
            (step && gap_q != '0) ? gap_q - GW'(1) : gap_q;
    cnt_d = cnt_q + 16'(spawn);
    val_d = val_q;
    x_d   = x_q;
    typ_d = typ_q;
    for (int i = 0; i < NSLOT; i++) begin
      if (clear) val_d[i] = 1'b0;
      else if (spawn && free_idx == IW'(i)) begin
        val_d[i] = 1'b1;
        x_d[i]   = 10'(RIGHT_X);
        typ_d[i] = lfsr_q[1:0];
      end else if (step && val_q[i]) begin
        if (x_q[i] < 10'(LEFT_X + SPEED)) val_d[i] = 1'b0;
        else x_d[i] = x_q[i] - 10'(SPEED);
      end
    end
  end
  // Lowest-index hitting slot wins, so scan downwards and let lower slots overwrite.
  always_comb begin
    h11 = {1'b0, hCount};
    v11 = {1'b0, vCount};
    x11 = '0;
    top = '0;
    bot = '0;
    t   = '0;
    pix_d = v11 == GY ? (CIDXW+1)'(8) : (CIDXW+1)'(1);
    for (int i = NSLOT - 1; i >= 0; i--) begin
      t   = typ_q[i] == 2'd3 ? 2'd0 : typ_q[i];
      x11 = {1'b0, x_q[i]};
      top = t == 2'd2 ? GY - 11'd72 : t == 2'd1 ? GY - 11'd48 : GY - 11'd32;
      bot = t == 2'd2 ? GY - 11'd57 : GY - 11'd1;
      if (val_q[i] && h11 >= x11 && h11 <= x11 + (t == 2'd2 ? 11'd31 : 11'd15) &&
          v11 >= top && v11 <= bot)
        pix_d = (CIDXW+1)'(3 + t);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
      div_q  <= '0;
      gap_q  <= GW'(MIN_GAP);
      val_q  <= '0;
      x_q    <= '0;
      typ_q  <= '0;
      cnt_q  <= '0;
      pix_q  <= (CIDXW+1)'(1);
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      div_q  <= div_d;
      gap_q  <= gap_d;
      val_q  <= val_d;
      x_q    <= x_d;
      typ_q  <= typ_d;
      cnt_q  <= cnt_d;
      pix_q  <= pix_d;
    end
  end
  assign pix         = pix_q;
  assign active_mask = val_q;
  assign spawn_count = cnt_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: scoreboard bench with a behavioural reference model of the obstacle pool.
module tb_obstacle_scheduler;
  localparam int NSLOT = 4, MOVE_DIV = 2, SPEED = 4, MIN_GAP = 12;
  localparam int GY = 400, LEFT_X = 144, RIGHT_X = 784;
  logic clk = 0, rst_n = 0, run = 0, clear = 0, frame_tick = 0;
  logic [9:0] hCount = 0, vCount = 0;
  logic [3:0] pix;
  logic [NSLOT-1:0] active_mask;
  logic [15:0] spawn_count;
  obstacle_scheduler dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clear(clear), .frame_tick(frame_tick),
    .hCount(hCount), .vCount(vCount), .pix(pix), .active_mask(active_mask),
    .spawn_count(spawn_count)
  );
  always #5 clk = ~clk;
  typedef struct { int mask; int cnt; int pix; } exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_err = 0;
  bit m_v[NSLOT];
  int m_x[NSLOT], m_t[NSLOT];
  int m_gap, m_div, m_cnt;
  logic [15:0] m_lfsr;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NSLOT; i++) begin m_v[i] = 0; m_x[i] = 0; m_t[i] = 0; end
    m_gap = MIN_GAP; m_div = 0; m_cnt = 0; m_lfsr = 16'hACE1;
    exp_q.delete();
  endtask
  function automatic int m_mask();
    int m = 0;
    for (int i = 0; i < NSLOT; i++) if (m_v[i]) m |= (1 << i);
    return m;
  endfunction
  function automatic int pix_of(int h, int v);
    for (int i = 0; i < NSLOT; i++) begin
      int t = (m_t[i] == 3) ? 0 : m_t[i];
      int w = (t == 2) ? 32 : 16;
      int top = (t == 0) ? GY - 32 : (t == 1) ? GY - 48 : GY - 72;
      int bot = (t == 2) ? GY - 57 : GY - 1;
      if (m_v[i] && h >= m_x[i] && h < m_x[i] + w && v >= top && v <= bot) return 3 + t;
    end
    return (v == GY) ? 8 : 1;
  endfunction
  task automatic pick_scan(output int h, output int v);
    int r = $urandom_range(0, 3);
    int s = $urandom_range(0, NSLOT - 1);
    h = $urandom_range(0, 799);
    v = $urandom_range(0, 524);
    if (r == 1) v = GY;
    else if (r >= 2 && m_v[s]) begin
      h = m_x[s] + $urandom_range(0, 35) - 2;
      v = GY - $urandom_range(0, 80);
    end
  endtask
  task automatic cyc(bit r, bit c, bit ft);
    int h, v, f;
    exp_t e;
    pick_scan(h, v);
    run = r; clear = c; frame_tick = ft; hCount = 10'(h); vCount = 10'(v);
    e.pix = pix_of(h, v);
    if (c) begin
      for (int i = 0; i < NSLOT; i++) m_v[i] = 0;
      m_div = 0; m_gap = MIN_GAP;
    end else if (r && ft) begin
      if (m_div == MOVE_DIV - 1) begin
        m_div = 0;
        f = -1;
        for (int i = NSLOT - 1; i >= 0; i--) if (!m_v[i]) f = i;
        for (int i = 0; i < NSLOT; i++)
          if (m_v[i]) begin
            if (m_x[i] < LEFT_X + SPEED) m_v[i] = 0;
            else m_x[i] -= SPEED;
          end
        if (m_gap == 0 && f >= 0) begin
          m_v[f] = 1; m_x[f] = RIGHT_X; m_t[f] = m_lfsr[1:0];
          m_gap = MIN_GAP + m_lfsr[5:2];
          m_cnt = (m_cnt + 1) & 16'hFFFF;
        end else if (m_gap > 0) m_gap--;
      end else m_div++;
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    e.mask = m_mask();
    e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("mask", 32'(active_mask), e.mask);
    check("count", 32'(spawn_count), e.cnt);
    check("pix", 32'(pix), e.pix);
  endtask
  task automatic step();
    repeat (MOVE_DIV) begin cyc(1, 0, 1); cyc(1, 0, 0); end
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pix", 32'(pix), 1);
    check("rst_mask", 32'(active_mask), 0);
    check("rst_count", 32'(spawn_count), 0);
    rst_n = 1;
    repeat (12) step();
    check("gap_no_spawn", 32'(active_mask), 0);
    step();
    check("first_spawn_mask", 32'(active_mask), 1);
    check("first_spawn_count", 32'(spawn_count), 1);
    for (int s = 14; s <= 175; s++) begin
      step();
      if (s == 150) begin
        check("full_mask", 32'(active_mask), 4'hF);
        check("full_no_spawn", 32'(spawn_count), 4);
      end
      if (s == 173) check("slot0_at_left", 32'(active_mask[0]), 1);
      if (s == 174) begin
        check("slot0_retired", 32'(active_mask[0]), 0);
        check("retire_no_reuse", 32'(spawn_count), 4);
      end
      if (s == 175) begin
        check("respawn_mask", 32'(active_mask), 4'hF);
        check("respawn_count", 32'(spawn_count), 5);
      end
    end
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    check("clear_mask", 32'(active_mask), 0);
    check("clear_count", 32'(spawn_count), 5);
    repeat (12) step();
    check("clear_gap", 32'(active_mask), 0);
    step();
    check("post_clear_spawn", 32'(spawn_count), 6);
    check("post_clear_mask", 32'(active_mask), 1);
    repeat (10) begin cyc(0, 0, 1); cyc(0, 0, 0); end
    check("frozen_mask", 32'(active_mask), 1);
    check("frozen_count", 32'(spawn_count), 6);
    repeat (20) step();
    #2 rst_n = 0;
    #1;
    check("async_pix", 32'(pix), 1);
    check("async_mask", 32'(active_mask), 0);
    check("async_count", 32'(spawn_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (13) step();
    check("restart_count", 32'(spawn_count), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
